clkgate_ctrl: RTL and testbench

Clock-gate sequencer for a shared gated clock domain. Arbitrates enable requests from `NumReq` requesters and drives the enable of a downstream `prim_clock_gating` instance. Inserts a wake-up settling window before granting and an idle hysteresis window before gating. Sits in the always-on clock domain next to the gate cell it controls.

---
 rtl/clkgate_ctrl.sv | 155 +++++++++++++++
 tb/tb_clkgate_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/clkgate_ctrl.sv
// clkgate_ctrl: clock-gate sequencer for a shared gated clock domain.
//
// Collects level requests from NumReq requesters and drives the enable of a
// downstream clock-gate cell. A wake-up settling window of WakeCycles cycles
// separates the enable rising from the first grant. An idle hysteresis window
// of IdleCycles cycles separates the last request dropping from the enable
// falling. A request arriving during the hysteresis window returns straight to
// ON, because the gated clock never stopped.
//
// Optional build macro: CLKGATE_CTRL_STATS_EN
//   When it is defined, gated_cnt_o counts cycles spent in OFF. The count
//   saturates at all-ones and is cleared by cnt_clr_i.
//   When it is undefined, gated_cnt_o is tied to zero and cnt_clr_i is
//   ignored. The ports exist in both builds.
//
// Request/grant handshake: req_i[i] is a level request that the requester
// holds high for as long as it needs the clock. ack_o[i] is high only while
// the controller is ON and req_i[i] is high, and the gated clock is valid
// whenever ack_o[i] is high. Grants are not exclusive: every active requester
// is granted together. A requester that drops req_i loses its ack in the same
// cycle.
//
// The FSM state is visible on state_o (OFF=0, WAKE=1, ON=2, IDLE=3) so that
// checkers can bind to it directly.

module clkgate_ctrl #(
  parameter int NumReq     = 4,
  parameter int WakeCycles = 2,
  parameter int IdleCycles = 8,
  parameter int CntW       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] ack_o,
  output logic              en_o,
  output logic              busy_o,
  output logic [1:0]        state_o,
  input  logic              cnt_clr_i,
  output logic [CntW-1:0]   gated_cnt_o
);

  localparam logic [1:0] StOff  = 2'd0;
  localparam logic [1:0] StWake = 2'd1;
  localparam logic [1:0] StOn   = 2'd2;
  localparam logic [1:0] StIdle = 2'd3;

  // The window counter must hold the larger of the two load values. The
  // floor of 2 keeps the counter at least one bit wide.
  localparam int MaxWin = (WakeCycles > IdleCycles) ?
                          ((WakeCycles > 2) ? WakeCycles : 2) :
                          ((IdleCycles > 2) ? IdleCycles : 2);
  localparam int CntLen = $clog2(MaxWin);

  localparam logic [CntLen-1:0] WakeLoad = CntLen'(WakeCycles - 1);
  // IdleLoad is only used when IdleCycles > 0. The guard keeps the value
  // non-negative for the IdleCycles == 0 build.
  localparam logic [CntLen-1:0] IdleLoad =
    CntLen'((IdleCycles > 0) ? (IdleCycles - 1) : 0);

  logic [1:0]        state_q, state_d;
  logic [CntLen-1:0] cnt_q, cnt_d;
  logic              en_q;
  logic              any_req;

  assign any_req = |req_i;

  // Next-state and window-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StOff: begin
        if (any_req) begin
          state_d = StWake;
          cnt_d   = WakeLoad;
        end
      end
      StWake: begin
        // Changes on the requests do not cut the settling window short.
        if (cnt_q == '0) begin
          state_d = StOn;
        end else begin
          cnt_d = cnt_q - CntLen'(1);
        end
      end
      StOn: begin
        if (!any_req) begin
          if (IdleCycles == 0) begin
            state_d = StOff;
          end else begin
            state_d = StIdle;
            cnt_d   = IdleLoad;
          end
        end
      end
      StIdle: begin
        // A request wins over window expiry, even on the cnt == 0 cycle.
        if (any_req) begin
          state_d = StOn;
        end else if (cnt_q == '0) begin
          state_d = StOff;
        end else begin
          cnt_d = cnt_q - CntLen'(1);
        end
      end
      default: begin
        state_d = StOff;
        cnt_d   = '0;
      end
    endcase
  end

  // State, window counter and registered gate enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StOff;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= (state_d != StOff);
    end
  end

  assign en_o    = en_q;
  assign state_o = state_q;
  assign busy_o  = (state_q != StOff);
  assign ack_o   = (state_q == StOn) ? req_i : '0;

`ifdef CLKGATE_CTRL_STATS_EN
  logic [CntW-1:0] gated_cnt_q;

  // Saturating count of cycles spent gated. A clear takes priority over the
  // increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gated_cnt_q <= '0;
    end else if (cnt_clr_i) begin
      gated_cnt_q <= '0;
    end else if ((state_q == StOff) && (gated_cnt_q != '1)) begin
      gated_cnt_q <= gated_cnt_q + CntW'(1);
    end
  end

  assign gated_cnt_o = gated_cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr_i;
  assign gated_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_clkgate_ctrl.sv
// tb_clkgate_ctrl: self-checking bench for clkgate_ctrl.
// It runs a default-parameter instance (dut) and a corner instance (dut_c)
// with WakeCycles=1, IdleCycles=0 and CntW=4.

module tb_clkgate_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] req, req_c;
  logic [3:0] ack, ack_c;
  logic       en, en_c;
  logic       busy, busy_c;
  logic [1:0] st, st_c;
  logic       clr;
  logic [15:0] gcnt;
  logic [3:0]  gcnt_c;

  int checks   = 0;
  int failures = 0;

  // Each entry is {dut select, state, en, ack}.
  logic [7:0] exp_q[$];

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [1:0] st;
    logic       en;
    logic [3:0] ack;
  } vec_t;

  vec_t tbl[$];

  clkgate_ctrl dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .ack_o(ack), .en_o(en),
    .busy_o(busy), .state_o(st), .cnt_clr_i(clr), .gated_cnt_o(gcnt)
  );

  clkgate_ctrl #(.NumReq(4), .WakeCycles(1), .IdleCycles(0), .CntW(4)) dut_c (
    .clk_i(clk), .rst_i(rst), .req_i(req_c), .ack_o(ack_c), .en_o(en_c),
    .busy_o(busy_c), .state_o(st_c), .cnt_clr_i(clr), .gated_cnt_o(gcnt_c)
  );

  // Clock and initial reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input int n, input logic r, input logic [3:0] rq,
                     input logic [1:0] s, input logic e, input logic [3:0] a);
    vec_t v;
    v.rst = r; v.req = rq; v.st = s; v.en = e; v.ack = a;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  // Drive one cycle on the selected instance, queue its expectation, then pop
  // and compare away from the active edge.
  task automatic drive_cycle(input logic sel, input logic r, input logic [3:0] rq,
                             input logic [1:0] s, input logic e, input logic [3:0] a);
    logic [7:0] item;
    @(posedge clk);
    #1;
    rst = r;
    if (sel) begin req_c = rq; req = 4'h0; end
    else     begin req = rq;   req_c = 4'h0; end
    exp_q.push_back({sel, s, e, a});
    @(negedge clk);
    item = exp_q.pop_front();
    if (item[7]) begin
      check("c_state", 16'(st_c), 16'(item[6:5]));
      check("c_en",    16'(en_c), 16'(item[4]));
      check("c_ack",   16'(ack_c), 16'(item[3:0]));
      check("c_busy",  16'(busy_c), 16'(item[6:5] != 2'd0));
    end else begin
      check("state", 16'(st), 16'(item[6:5]));
      check("en",    16'(en), 16'(item[4]));
      check("ack",   16'(ack), 16'(item[3:0]));
      check("busy",  16'(busy), 16'(item[6:5] != 2'd0));
    end
`ifndef CLKGATE_CTRL_STATS_EN
    check("gcnt_tied", gcnt, 16'h0);
    check("gcnt_c_tied", 16'(gcnt_c), 16'h0);
`endif
  endtask

  initial begin
    rst = 1'b1; req = 4'h0; req_c = 4'h0; clr = 1'b0;
    repeat (3) @(posedge clk);

    // Reset held with all requests up, then WAKE on the first free cycle.
    add(2, 1, 4'hF, 0, 0, 4'h0);
    add(1, 0, 4'hF, 0, 0, 4'h0);
    add(2, 0, 4'hF, 1, 1, 4'h0);
    add(1, 0, 4'hF, 2, 1, 4'hF);
    add(1, 0, 4'h0, 2, 1, 4'h0);
    add(8, 0, 4'h0, 3, 1, 4'h0);
    add(1, 0, 4'h0, 0, 0, 4'h0);
    // Single wake/release: req in cycle 0, ack from 3, drop at 10, en low at 19.
    add(1, 0, 4'h1, 0, 0, 4'h0);
    add(2, 0, 4'h1, 1, 1, 4'h0);
    add(7, 0, 4'h1, 2, 1, 4'h1);
    add(1, 0, 4'h0, 2, 1, 4'h0);
    add(8, 0, 4'h0, 3, 1, 4'h0);
    add(1, 0, 4'h0, 0, 0, 4'h0);
    // Hysteresis re-hit 5 cycles into IDLE, then on the cnt == 0 cycle.
    add(1, 0, 4'h4, 0, 0, 4'h0);
    add(2, 0, 4'h4, 1, 1, 4'h0);
    add(1, 0, 4'h4, 2, 1, 4'h4);
    add(1, 0, 4'h0, 2, 1, 4'h0);
    add(5, 0, 4'h0, 3, 1, 4'h0);
    add(1, 0, 4'h4, 3, 1, 4'h0);
    add(1, 0, 4'h4, 2, 1, 4'h4);
    add(1, 0, 4'h0, 2, 1, 4'h0);
    add(7, 0, 4'h0, 3, 1, 4'h0);
    add(1, 0, 4'h4, 3, 1, 4'h0);
    add(1, 0, 4'h4, 2, 1, 4'h4);
    add(1, 0, 4'h0, 2, 1, 4'h0);
    add(8, 0, 4'h0, 3, 1, 4'h0);
    add(1, 0, 4'h0, 0, 0, 4'h0);
    // Overlapping requesters 1 and 3.
    add(3, 0, 4'h2, 0, 0, 4'h0);
    tbl[tbl.size()-2].st = 1; tbl[tbl.size()-2].en = 1;
    tbl[tbl.size()-1].st = 1; tbl[tbl.size()-1].en = 1;
    add(1, 0, 4'h2, 2, 1, 4'h2);
    add(3, 0, 4'hA, 2, 1, 4'hA);
    add(2, 0, 4'h8, 2, 1, 4'h8);
    add(1, 0, 4'h0, 2, 1, 4'h0);
    add(8, 0, 4'h0, 3, 1, 4'h0);
    add(1, 0, 4'h0, 0, 0, 4'h0);
    // Reset mid-WAKE, then mid-ON.
    add(1, 0, 4'h1, 0, 0, 4'h0);
    add(1, 1, 4'h1, 1, 1, 4'h0);
    add(1, 0, 4'h1, 0, 0, 4'h0);
    add(2, 0, 4'h1, 1, 1, 4'h0);
    add(1, 0, 4'h1, 2, 1, 4'h1);
    add(1, 1, 4'h1, 2, 1, 4'h1);
    add(2, 0, 4'h0, 0, 0, 4'h0);

    for (int i = 0; i < tbl.size(); i++)
      drive_cycle(1'b0, tbl[i].rst, tbl[i].req, tbl[i].st, tbl[i].en, tbl[i].ack);

    // Corner instance: WakeCycles=1, IdleCycles=0.
    drive_cycle(1'b1, 0, 4'h1, 0, 0, 4'h0);
    drive_cycle(1'b1, 0, 4'h1, 1, 1, 4'h0);
    drive_cycle(1'b1, 0, 4'h1, 2, 1, 4'h1);
    drive_cycle(1'b1, 0, 4'h1, 2, 1, 4'h1);
    drive_cycle(1'b1, 0, 4'h0, 2, 1, 4'h0);
    drive_cycle(1'b1, 0, 4'h0, 0, 0, 4'h0);
    drive_cycle(1'b1, 0, 4'h1, 0, 0, 4'h0);
    drive_cycle(1'b1, 1, 4'h1, 1, 1, 4'h0);
    drive_cycle(1'b1, 0, 4'h1, 0, 0, 4'h0);
    drive_cycle(1'b1, 0, 4'h1, 1, 1, 4'h0);
    drive_cycle(1'b1, 0, 4'h1, 2, 1, 4'h1);
    drive_cycle(1'b1, 1, 4'h1, 2, 1, 4'h1);
    drive_cycle(1'b1, 0, 4'h0, 0, 0, 4'h0);
    drive_cycle(1'b1, 0, 4'h0, 0, 0, 4'h0);

    // Statistics: clear, then 100 OFF cycles on both instances.
    @(posedge clk);
    #1;
    req = 4'h0; req_c = 4'h0; clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
`ifdef CLKGATE_CTRL_STATS_EN
    check("gcnt_clr", gcnt, 16'd0);
    check("gcnt_c_clr", 16'(gcnt_c), 16'd0);
`else
    check("gcnt_tied", gcnt, 16'd0);
`endif
    repeat (100) @(posedge clk);
    @(negedge clk);
`ifdef CLKGATE_CTRL_STATS_EN
    check("gcnt_100", gcnt, 16'd100);
    check("gcnt_c_sat", 16'(gcnt_c), 16'd15);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("gcnt_clr2", gcnt, 16'd0);
    check("gcnt_c_clr2", 16'(gcnt_c), 16'd0);
`else
    check("gcnt_tied", gcnt, 16'd0);
    check("gcnt_c_tied", 16'(gcnt_c), 16'd0);
`endif

    check("exp_q_empty", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
